// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
//
// Time-multiplexed scan controller for a bank of seven-segment digits that
// share one hex-to-segment decoder. Each digit is lit for DIV clock cycles,
// one at a time, from digit 0 (rightmost) up to digit DIGITS-1. New display
// values are taken through a one-deep shadow register and only moved into the
// displayed (active) value at the end of a full frame, so a frame never shows
// a mix of old and new digits.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   load_valid  requester offers a new display value
//   load_ready  high while the shadow register is free (no value pending)
//   value       4*DIGITS-bit hex value, nibble k shown on digit k
//   blank_lz    enables leading-zero blanking (applied combinationally)
//   dig_sel     nibble for the shared hex-to-segment decoder
//   an          active-low digit enables, at most one bit low
//   frame_done  one-cycle pulse in the last cycle of the last digit's slot
// -----------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [3:0]            dig_sel,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    // With DIV=1 the divider degenerates to a single bit that stays at zero,
    // so every cycle is a tick.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    logic [CW-1:0]         cnt_reg,    cnt_next;
    logic [IW-1:0]         idx_reg,    idx_next;
    logic [4*DIGITS-1:0]   active_reg, active_next;
    logic [4*DIGITS-1:0]   shadow_reg, shadow_next;
    logic                  pend_reg,   pend_next;

    logic                  tick;
    logic                  frame_wrap;
    logic                  load_accept;
    logic [DIGITS-1:0]     upper_zero;
    logic                  blank;

    assign tick        = (cnt_reg == CNT_LAST);
    assign frame_wrap  = tick && (idx_reg == IDX_LAST);
    assign load_ready  = ~pend_reg;
    assign load_accept = load_valid && ~pend_reg;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        active_next = active_reg;
        shadow_next = shadow_reg;
        pend_next   = pend_reg;

        if (tick) begin
            cnt_next = '0;
            if (idx_reg == IDX_LAST) begin
                idx_next = '0;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end

        // Pending value is promoted only at the frame boundary, so it first
        // shows up on digit 0 of the next frame.
        if (frame_wrap && pend_reg) begin
            active_next = shadow_reg;
            pend_next   = 1'b0;
        end

        // A load needs pend clear, so it can never collide with the promotion
        // above; a load in the wrap cycle waits for the following wrap.
        if (load_accept) begin
            shadow_next = value;
            pend_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            idx_reg    <= '0;
            active_reg <= '0;
            shadow_reg <= '0;
            pend_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            active_reg <= active_next;
            shadow_reg <= shadow_next;
            pend_reg   <= pend_next;
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero detection: upper_zero[k] is set when nibbles k..DIGITS-1 of
    // the displayed value are all zero.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_upper_zero
            assign upper_zero[gi] = ~|active_reg[4*DIGITS-1:4*gi];
        end
    endgenerate

    // Digit 0 is never blanked so an all-zero value still shows a single "0".
    assign blank = blank_lz && (idx_reg != '0) && upper_zero[idx_reg];

    // -------------------------------------------------------------------------
    // Outputs, straight from registered state (no extra pipeline stage)
    // -------------------------------------------------------------------------
    assign dig_sel    = active_reg[4*idx_reg +: 4];
    assign an         = blank ? '1 : ~(ONE_HOT0 << idx_reg);
    assign frame_done = frame_wrap;

endmodule
